// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_DONE = 2'd2
  } dm_state_e;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_req_t;
endpackage

// File: rtl/dm_resp_if.sv
// MEM-stage request/response bundle for dm_resp.
// DMEM_PERF_EN adds the load/store/stall performance counters.
interface dm_resp_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        stall;
  logic        misalign;
`ifdef DMEM_PERF_EN
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;
  logic [31:0] stall_cnt;

  modport master (
    output mem_read, mem_write, funct3, addr, wdata,
    input  rdata, rdata_valid, stall, misalign, load_cnt, store_cnt, stall_cnt
  );
  modport slave (
    input  mem_read, mem_write, funct3, addr, wdata,
    output rdata, rdata_valid, stall, misalign, load_cnt, store_cnt, stall_cnt
  );
`else
  modport master (
    output mem_read, mem_write, funct3, addr, wdata,
    input  rdata, rdata_valid, stall, misalign
  );
  modport slave (
    input  mem_read, mem_write, funct3, addr, wdata,
    output rdata, rdata_valid, stall, misalign
  );
`endif
endinterface

// File: rtl/dm_resp_align.sv
// Byte-lane steering: store enables/replication, load extraction, legality.
module dm_align
  import dmem_pkg::*;
(
  input  logic [2:0]                           funct3,
  input  logic [1:0]                           off,
  input  logic [31:0]                          wdata,
  input  logic [31:0]                          raw,
  output logic [NUM_LANES-1:0]                 be,
  output logic [NUM_LANES-1:0][LANE_W-1:0]     wrep,
  output logic [31:0]                          rdata,
  output logic                                 misalign
);
  logic [NUM_LANES-1:0][LANE_W-1:0] raw_b;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  assign raw_b = raw;
  assign sel_b = raw_b[off];
  assign sel_h = off[1] ? raw[31:16] : raw[15:0];

  // funct3[1:0] gives the access size; each lane picks its source byte.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign wrep[g] = (funct3[1:0] == 2'b00) ? wdata[7:0] :
                     (funct3[1:0] == 2'b01) ? wdata[8*(g%2) +: 8] :
                                              wdata[8*g +: 8];
  end

  always_comb begin
    be       = '0;
    misalign = 1'b0;
    case (funct3)
      DM_B, DM_BU: be = 4'b0001 << off;
      DM_H, DM_HU: begin
        be       = 4'b0011 << {off[1], 1'b0};
        misalign = off[0];
      end
      DM_W: begin
        be       = 4'b1111;
        misalign = |off;
      end
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    rdata = raw;
    case (funct3)
      DM_B:    rdata = {{24{sel_b[7]}}, sel_b};
      DM_BU:   rdata = {24'b0, sel_b};
      DM_H:    rdata = {{16{sel_h[15]}}, sel_h};
      DM_HU:   rdata = {16'b0, sel_h};
      default: rdata = raw;
    endcase
  end
endmodule

// File: rtl/dm_resp.sv
// RV32I data-memory responder: stalls for LAT+1 cycles, completes in DONE.
// DMEM_PERF_EN adds load/store/stall counters on the interface.
module dm_resp
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input  logic       clk,
  input  logic       rstn,
  dm_resp_if.slave   bus
);
  localparam int         DEPTH  = 2**ADDR_W;
  localparam logic [3:0] LAT_LD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  dm_state_e state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [NUM_LANES-1:0][LANE_W-1:0] mem [DEPTH];

  dm_req_t                          req;
  logic                             is_req, is_store, is_load, bad, ld_cap, wr_en;
  logic [NUM_LANES-1:0]             be;
  logic [NUM_LANES-1:0][LANE_W-1:0] wrep;
  logic [31:0]                      ld_data;
  logic [ADDR_W-1:0]                widx;
  logic                             unused_addr;

  assign req = '{rd: bus.mem_read, wr: bus.mem_write, funct3: bus.funct3,
                 addr: bus.addr, wdata: bus.wdata};

  assign is_req      = req.rd | req.wr;
  assign is_store    = req.wr;
  assign is_load     = req.rd & ~req.wr;
  assign widx        = req.addr[ADDR_W+1:2];
  assign unused_addr = ^req.addr[31:ADDR_W+2];

  dm_align u_align (
    .funct3   (req.funct3),
    .off      (req.addr[1:0]),
    .wdata    (req.wdata),
    .raw      (mem[widx]),
    .be       (be),
    .wrep     (wrep),
    .rdata    (ld_data),
    .misalign (bad)
  );

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bus.stall     = 1'b0;
    bus.misalign  = 1'b0;
    case (state)
      DM_IDLE: if (is_req) begin
        if (bad) begin
          bus.misalign = 1'b1;
        end else begin
          bus.stall = 1'b1;
          if (LAT > 0) begin
            state_nxt = DM_WAIT;
            cnt_nxt   = LAT_LD;
          end else begin
            state_nxt = DM_DONE;
          end
        end
      end
      DM_WAIT: begin
        bus.stall = 1'b1;
        if (cnt == 4'd0) state_nxt = DM_DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      DM_DONE: state_nxt = DM_IDLE;
      default: state_nxt = DM_IDLE;
    endcase
    // The pipeline must never see a stall or fault while reset is held.
    if (!rstn) begin
      bus.stall    = 1'b0;
      bus.misalign = 1'b0;
    end
  end

  // Load data is captured on the edge entering DONE so it is valid there.
  assign ld_cap = (state_nxt == DM_DONE) && is_load;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= DM_IDLE;
      cnt             <= '0;
      bus.rdata       <= '0;
      bus.rdata_valid <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      bus.rdata_valid <= ld_cap;
      if (ld_cap) bus.rdata <= ld_data;
    end
  end

  assign wr_en = rstn && (state == DM_DONE) && is_store;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (be[i]) mem[widx][i] <= wrep[i];
      end
    end
  end

`ifdef DMEM_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.load_cnt  <= '0;
      bus.store_cnt <= '0;
      bus.stall_cnt <= '0;
    end else begin
      if (state == DM_DONE && is_load)  bus.load_cnt  <= bus.load_cnt + 32'd1;
      if (state == DM_DONE && is_store) bus.store_cnt <= bus.store_cnt + 32'd1;
      if (bus.stall)                    bus.stall_cnt <= bus.stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dm_resp.sv
// Self-checking bench for dm_resp: directed plan steps plus random traffic
// against a word-array reference model.
module tb_dm_resp;
  import dmem_pkg::*;

  localparam int LAT = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] mdl [1024];
  logic [31:0] last_rd = '0;
  int          m_load = 0, m_store = 0, m_stall = 0;

  dm_resp_if bus ();

  dm_resp #(.ADDR_W(10), .LAT(LAT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit f3_legal(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (a % 2) == 0;
      3'd2:       return (a % 4) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ld_exp(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    int b, h;
    b = int'((w >> ((a % 4) * 8)) & 32'hFF);
    h = int'((w >> (((a % 4) / 2) * 16)) & 32'hFFFF);
    case (f3)
      3'd0:    return (b >= 128)   ? 32'(b - 256)   : 32'(b);
      3'd4:    return 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w, input logic [31:0] wd);
    int n, k;
    logic [31:0] byt;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) begin
      k   = int'(a % 4) + i;
      byt = (wd >> (8 * i)) & 32'hFF;
      w   = (w & ~(32'hFF << (8 * k))) | (byt << (8 * k));
    end
    return w;
  endfunction

  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    int          idx;
    logic [31:0] exp;
    @(negedge clk);
    bus.mem_read = rd; bus.mem_write = wr; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    #1;
    idx = int'((a / 4) % 1024);
    if (!rd && !wr) begin
      chk("idle_stall", {31'b0, bus.stall}, 32'd0);
      chk("idle_vld", {31'b0, bus.rdata_valid}, 32'd0);
      return;
    end
    if (!f3_legal(f3, a)) begin
      chk("mis_pulse", {31'b0, bus.misalign}, 32'd1);
      chk("mis_stall", {31'b0, bus.stall}, 32'd0);
      chk("mis_vld", {31'b0, bus.rdata_valid}, 32'd0);
      chk("mis_hold", bus.rdata, last_rd);
      return;
    end
    exp = ld_exp(f3, a, mdl[idx]);
    for (int c = 0; c <= LAT; c++) begin
      chk("busy_stall", {31'b0, bus.stall}, 32'd1);
      chk("busy_vld", {31'b0, bus.rdata_valid}, 32'd0);
      chk("busy_mis", {31'b0, bus.misalign}, 32'd0);
      @(negedge clk); #1;
    end
    chk("done_stall", {31'b0, bus.stall}, 32'd0);
    chk("done_vld", {31'b0, bus.rdata_valid}, {31'b0, rd && !wr});
    m_stall += LAT + 1;
    if (wr) begin
      mdl[idx] = st_merge(f3, a, mdl[idx], wd);
      m_store++;
    end else begin
      chk("done_rdata", bus.rdata, exp);
      last_rd = exp;
      m_load++;
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
  endtask

  initial begin
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.funct3 = '0;
    bus.addr = '0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_stall", {31'b0, bus.stall}, 32'd0);
    chk("rst_vld", {31'b0, bus.rdata_valid}, 32'd0);
    chk("rst_mis", {31'b0, bus.misalign}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);

    // Give the modelled region known contents.
    for (int i = 0; i < 32; i++) access(1'b0, 1'b1, DM_W, 32'(i * 4), $urandom);

    access(1'b0, 1'b1, DM_W, 32'h10, 32'hDEADBEEF);
    access(1'b1, 1'b0, DM_W, 32'h10, 32'h0);
    chk("plan_lw10", bus.rdata, 32'hDEADBEEF);

    access(1'b0, 1'b1, DM_W, 32'h20, 32'h11223344);
    access(1'b0, 1'b1, DM_B, 32'h21, 32'h000000F0);
    access(1'b1, 1'b0, DM_B, 32'h21, 32'h0);
    chk("plan_lb21", bus.rdata, 32'hFFFFFFF0);
    access(1'b1, 1'b0, DM_BU, 32'h21, 32'h0);
    chk("plan_lbu21", bus.rdata, 32'h000000F0);
    access(1'b1, 1'b0, DM_W, 32'h20, 32'h0);
    chk("plan_lw20", bus.rdata, 32'h1122F044);

    access(1'b0, 1'b1, DM_W, 32'h30, 32'h0);
    access(1'b0, 1'b1, DM_H, 32'h32, 32'h00008001);
    access(1'b1, 1'b0, DM_H, 32'h32, 32'h0);
    chk("plan_lh32", bus.rdata, 32'hFFFF8001);
    access(1'b1, 1'b0, DM_HU, 32'h32, 32'h0);
    chk("plan_lhu32", bus.rdata, 32'h00008001);
    access(1'b1, 1'b0, DM_W, 32'h30, 32'h0);
    chk("plan_lw30", bus.rdata, 32'h80010000);

    access(1'b1, 1'b0, DM_W, 32'h13, 32'h0);
    access(1'b1, 1'b0, DM_H, 32'h15, 32'h0);
    access(1'b0, 1'b1, 3'b011, 32'h10, 32'h12345678);
    access(1'b1, 1'b0, DM_W, 32'h10, 32'h0);
    chk("plan_after_mis", bus.rdata, 32'hDEADBEEF);
    // load+store together behaves as a store
    access(1'b1, 1'b1, DM_W, 32'h18, 32'hCAFEF00D);
    access(1'b1, 1'b0, DM_W, 32'h18, 32'h0);
    chk("plan_rdwr", bus.rdata, 32'hCAFEF00D);

    // Reset during WAIT drops the store.
    @(negedge clk);
    bus.mem_read = 1'b0; bus.mem_write = 1'b1; bus.funct3 = DM_W;
    bus.addr = 32'h40; bus.wdata = 32'h55;
    #1 chk("rstw_stall0", {31'b0, bus.stall}, 32'd1);
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1; bus.mem_write = 1'b0;
    #1;
    chk("rstw_stall", {31'b0, bus.stall}, 32'd0);
    chk("rstw_rdata", bus.rdata, 32'd0);
    last_rd = '0; m_load = 0; m_store = 0; m_stall = 0;
    access(1'b1, 1'b0, DM_W, 32'h40, 32'h0);

    // Reset during DONE also suppresses the write.
    @(negedge clk);
    bus.mem_read = 1'b0; bus.mem_write = 1'b1; bus.funct3 = DM_W;
    bus.addr = 32'h44; bus.wdata = 32'hA5A5A5A5;
    repeat (LAT + 1) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk); rstn = 1'b1; bus.mem_write = 1'b0;
    last_rd = '0; m_load = 0; m_store = 0; m_stall = 0;
    access(1'b1, 1'b0, DM_W, 32'h44, 32'h0);

    for (int n = 0; n < 150; n++) begin
      int          sel;
      bit          rd, wr;
      logic [31:0] a;
      sel = int'($urandom_range(0, 9));
      rd  = 1'($urandom_range(0, 1));
      wr  = (sel == 0) ? 1'b0 : (!rd ? 1'b1 : 1'($urandom_range(0, 1)));
      if (sel == 0) rd = 1'b0;
      a = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 31)) << 2) |
          32'($urandom_range(0, 3));
      access(rd, wr, 3'($urandom_range(0, 7)), a, $urandom);
    end
    go_idle();
    #1;
    chk("end_stall", {31'b0, bus.stall}, 32'd0);
`ifdef DMEM_PERF_EN
    chk("perf_load", bus.load_cnt, 32'(m_load));
    chk("perf_store", bus.store_cnt, 32'(m_store));
    chk("perf_stall", bus.stall_cnt, 32'(m_stall));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
